// File: rtl/dmem_responder.sv
// Single-port data-memory responder: accepts one byte-lane request at a time,
// waits a fixed number of cycles, then holds the response until the core takes it.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_we,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        enter_resp;
  logic        illegal;
  logic        mem_wr;
  logic [31:0] cur_addr;
  logic [3:0]  cur_we;
  logic [31:0] cur_wdata;
  logic [AW-1:0] idx;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state_q == IDLE) && reset;
  assign accept    = req_valid && req_ready;

  // In IDLE the live request is the one being decided (matters for LATENCY=0);
  // afterwards only the captured copy is used, so input changes cannot leak in.
  assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign idx       = cur_addr[AW+1:2];

  always_comb begin
    illegal = 1'b0;
    if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS)) illegal = 1'b1;
    case (cur_we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: ;
      4'b0011, 4'b1100: if (cur_addr[0]) illegal = 1'b1;
      4'b1111:          if (cur_addr[1:0] != 2'b00) illegal = 1'b1;
      default:          illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          if (LATENCY > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      err_d   = illegal;
      rdata_d = (!illegal && cur_we == 4'b0000) ? mem[idx] : 32'h0;
    end
  end

  assign mem_wr = enter_resp && !illegal && (cur_we != 4'b0000);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Storage and captured request are never cleared; outputs are gated by state.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_we[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main scenarios
// and a LATENCY=0 instance for the zero-wait path.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [3:0]  req_we;
  logic [31:0] req_wdata;
  logic        rsp_ready;
  logic        sel0;

  logic        rdy2, rv2, re2, rdy0, rv0, re0;
  logic [31:0] rd2, rd0;
  logic        rdy, rv, re;
  logic [31:0] rd;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel0), .req_ready(rdy2),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(re2)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel0), .req_ready(rdy0),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(re0)
  );

  assign rdy = sel0 ? rdy0 : rdy2;
  assign rv  = sel0 ? rv0  : rv2;
  assign rd  = sel0 ? rd0  : rd2;
  assign re  = sel0 ? re0  : re2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction with rsp_ready held high.
  task automatic do_req(input logic s, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat, input string tag);
    int n;
    int lat;
    sel0 = s;
    n = 0;
    while (!rdy && n < 30) begin tick(); n++; end
    req_valid = 1'b1; req_addr = a; req_we = w; req_wdata = d; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFC; req_we = 4'b1111; req_wdata = 32'h0;
    check({tag, "_busy_rdy"}, {31'b0, rdy}, 32'd0);
    lat = 1;
    while (!rv && lat < 30) begin tick(); lat++; end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, {31'b0, re}, {31'b0, exp_err});
    tick();
    check({tag, "_done_valid"}, {31'b0, rv}, 32'd0);
    check({tag, "_done_rdy"}, {31'b0, rdy}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_we = 4'h0;
    req_wdata = 32'h0; rsp_ready = 1'b0; sel0 = 1'b0;
    tick(); tick();
    check("rst_rdy2",   {31'b0, rdy2}, 32'd0);
    check("rst_valid2", {31'b0, rv2},  32'd0);
    check("rst_err2",   {31'b0, re2},  32'd0);
    check("rst_rdata2", rd2,           32'h0);
    check("rst_rdy0",   {31'b0, rdy0}, 32'd0);
    reset = 1'b1;
    #1;
    check("post_rst_rdy2", {31'b0, rdy2}, 32'd1);

    do_req(1'b0, 32'h10, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0, 3, "sw10");
    do_req(1'b0, 32'h10, 4'b0000, 32'h0,        32'hDEADBEEF, 1'b0, 3, "lw10");
    do_req(1'b0, 32'h11, 4'b0010, 32'h55555555, 32'h0,        1'b0, 3, "sb11");
    do_req(1'b0, 32'h10, 4'b0000, 32'h0,        32'hDEAD55EF, 1'b0, 3, "lw10_sb");
    do_req(1'b0, 32'h12, 4'b1111, 32'h0BADCAFE, 32'h0,        1'b1, 3, "sw_misal");
    do_req(1'b0, 32'h10, 4'b0000, 32'h0,        32'hDEAD55EF, 1'b0, 3, "lw10_keep1");
    do_req(1'b0, 32'h10, 4'b0101, 32'hFFFFFFFF, 32'h0,        1'b1, 3, "we_bad");
    do_req(1'b0, 32'h13, 4'b1100, 32'hFFFFFFFF, 32'h0,        1'b1, 3, "sh_misal");
    do_req(1'b0, 32'(4*DEPTH), 4'b0000, 32'h0,  32'h0,        1'b1, 3, "lw_oob");
    do_req(1'b0, 32'h8000_0010, 4'b1111, 32'hFFFFFFFF, 32'h0, 1'b1, 3, "sw_alias");
    do_req(1'b0, 32'h10, 4'b0000, 32'h0,        32'hDEAD55EF, 1'b0, 3, "lw10_keep2");
    do_req(1'b0, 32'h12, 4'b1100, 32'h12341234, 32'h0,        1'b0, 3, "sh12");
    do_req(1'b0, 32'h13, 4'b0000, 32'h0,        32'h123455EF, 1'b0, 3, "lw13_unal");
    do_req(1'b0, 32'h20, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0, 3, "sw20");

    // Backpressure: hold rsp_ready low for five cycles in RESP.
    sel0 = 1'b0;
    req_valid = 1'b1; req_addr = 32'h20; req_we = 4'b0000; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0; req_addr = 32'h10;
    n = 0;
    while (!rv2 && n < 30) begin tick(); n++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'b0, rv2},  32'd1);
      check("bp_rdata", rd2,           32'hCAFEF00D);
      check("bp_rdy",   {31'b0, rdy2}, 32'd0);
      tick();
    end
    check("bp_hold_valid", {31'b0, rv2}, 32'd1);
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    #1;
    check("bp_done_cycle_rdy", {31'b0, rdy2}, 32'd0);
    tick();
    req_valid = 1'b0;
    check("bp_after_valid", {31'b0, rv2},  32'd0);
    check("bp_after_rdy",   {31'b0, rdy2}, 32'd1);

    // Reset while a write waits: the write must be dropped.
    req_valid = 1'b1; req_addr = 32'h20; req_we = 4'b1111; req_wdata = 32'h11111111;
    tick();
    req_valid = 1'b0;
    check("rw_wait_rdy", {31'b0, rdy2}, 32'd0);
    reset = 1'b0;
    #1;
    check("rw_rst_valid", {31'b0, rv2},  32'd0);
    check("rw_rst_err",   {31'b0, re2},  32'd0);
    check("rw_rst_rdata", rd2,           32'h0);
    check("rw_rst_rdy",   {31'b0, rdy2}, 32'd0);
    tick();
    check("rw_rst_rdy_edge", {31'b0, rdy2}, 32'd0);
    reset = 1'b1;
    #1;
    check("rw_rel_rdy", {31'b0, rdy2}, 32'd1);
    do_req(1'b0, 32'h20, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0, 3, "lw20_old");

    // Zero-latency instance.
    do_req(1'b1, 32'h08, 4'b1111, 32'h0BADF00D, 32'h0,        1'b0, 1, "l0_sw08");
    do_req(1'b1, 32'h08, 4'b0000, 32'h0,        32'h0BADF00D, 1'b0, 1, "l0_lw08");
    do_req(1'b1, 32'(4*DEPTH), 4'b0000, 32'h0,  32'h0,        1'b1, 1, "l0_oob");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, the number of 32-bit words of storage.
REQ-002 The block SHALL have parameter LATENCY, default 2, the number of wait cycles between request acceptance and response; legal range 0..15.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge except at reset.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  core presents a data-memory request.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_we  input  4  byte-lane write enables; 4'b0000 means a read.
REQ-009 req_wdata  input  32  store data, already lane-replicated by the core (sb/sh/sw).
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  core accepts the response.
REQ-012 rsp_rdata  output  32  full aligned read word; the core performs load extraction.
REQ-013 rsp_err  output  1  request was illegal and had no effect.

Function
REQ-014 The block SHALL implement the states IDLE, WAIT and RESP.
REQ-015 req_ready SHALL be 1 only in IDLE with reset high.
- A request is accepted when req_valid and req_ready are both 1.
- On acceptance, req_addr, req_we and req_wdata SHALL be captured.
- The next state SHALL be WAIT if LATENCY>0, else RESP.
REQ-016 WAIT SHALL hold for exactly LATENCY cycles using a down-counter loaded with LATENCY-1, then go to RESP.
- Accept-to-first-rsp_valid latency SHALL therefore be LATENCY+1 cycles.
REQ-017 A request SHALL be illegal, and rsp_err set, when any of the following holds:
- captured address word index (addr[31:2]) >= DEPTH_WORDS;
- req_we is not one of 0000, 0001, 0010, 0100, 1000, 0011, 1100, 1111;
- req_we is 0011/1100 with addr[0]!=0;
- req_we is 1111 with addr[1:0]!=0;
- req_we is 0000 with addr[1:0]!=0 is legal (reads return the aligned word).
REQ-018 A legal write SHALL update only the enabled byte lanes of word addr[31:2] on the edge entering RESP; disabled lanes SHALL be unchanged.
REQ-019 A legal read SHALL present word addr[31:2] on rsp_rdata in RESP; that value SHALL reflect all writes completed before acceptance.
REQ-020 For writes and for illegal requests, rsp_rdata SHALL be 32'h0.
REQ-021 In RESP, rsp_valid SHALL be 1, and rsp_rdata/rsp_err SHALL be held stable until rsp_ready is 1.
- The state SHALL return to IDLE on the edge where rsp_valid and rsp_ready are both 1.
- rsp_valid, rsp_err and rsp_rdata SHALL be 0 outside RESP.
REQ-022 A new request SHALL NOT be accepted in the cycle the response completes; req_ready SHALL rise the following cycle.
- Maximum throughput is one request per LATENCY+2 cycles.
REQ-023 req_* inputs SHALL be ignored outside IDLE; changes after acceptance SHALL NOT affect the transaction.
REQ-024 The address is 32 bits wide; addresses above the storage SHALL produce an error, never aliasing or wrap-around.

Reset
REQ-025 While reset is low:
- state SHALL be IDLE;
- the counter SHALL be 0;
- rsp_valid, rsp_err and rsp_rdata SHALL be 0;
- req_ready SHALL be 0.
REQ-026 Reset asserted in WAIT or RESP SHALL abort the transaction; a write in WAIT SHALL NOT be performed.
REQ-027 Storage contents SHALL NOT be cleared by reset.
REQ-028 req_ready SHALL become 1 in the first cycle after reset rises.

Verification
REQ-029 The bench SHALL cover the following directed scenarios:
- LATENCY=2: write addr 0x10, we=1111, data 0xDEADBEEF, rsp_ready=1. Then read 0x10 -> rsp_valid 3 cycles after each accept, read rsp_rdata=0xDEADBEEF, rsp_err=0.
- sb: addr 0x11, we=0010, data 0x55555555 over word 0xDEADBEEF, then read 0x10 -> 0xDEAD55EF.
- Illegal: we=1111 at addr 0x12 -> rsp_err=1, rsp_rdata=0, word 0x10 unchanged. Read addr 4*DEPTH_WORDS -> rsp_err=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0; complete on rsp_ready=1, req_ready=1 the next cycle.
- Reset low during WAIT of a write to 0x20, then read 0x20 -> old contents returned; outputs 0 during reset.
- LATENCY=0: read accepted in cycle N -> rsp_valid in cycle N+1.
